// File: rtl/bus_interconnect_nslave.sv
// rtl/bus_interconnect_nslave.sv - single-master, N-slave registered bus interconnect
// Optional access watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_interconnect_nslave #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int N_SLAVES   = 4,
    parameter int REGION_W   = 4,
    parameter int REGION_LSB = 28,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            m_address,
    input  logic [DATA_W-1:0]            m_WriteData,
    input  logic                         m_MemWrite,
    input  logic                         m_MemRead,
    output logic [DATA_W-1:0]            m_ReadData,
    output logic                         m_ready,
    output logic                         m_error,
    output logic [ADDR_W-1:0]            d_address,
    output logic [DATA_W-1:0]            d_WriteData,
    output logic [N_SLAVES-1:0]          d_MemWrite,
    output logic [N_SLAVES-1:0]          d_MemRead,
    input  logic [N_SLAVES*DATA_W-1:0]   d_ReadData,
    input  logic [N_SLAVES-1:0]          d_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_write;
    logic [REGION_W-1:0]  r_idx;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;

    logic                 w_req;
    logic [REGION_W-1:0]  w_idx;
    logic                 w_mapped;
    logic [DATA_W-1:0]    w_sel_rdata;
    logic                 w_sel_ready;
    logic                 w_expire;
    logic                 w_resp_load;
    logic                 w_resp_err;
    logic [DATA_W-1:0]    w_resp_data;
    logic [N_SLAVES-1:0]  w_wr_stb;
    logic [N_SLAVES-1:0]  w_rd_stb;

    assign w_req    = m_MemRead | m_MemWrite;
    assign w_idx    = m_address[REGION_LSB +: REGION_W];
    assign w_mapped = ({{(32-REGION_W){1'b0}}, w_idx} < 32'(N_SLAVES));

    // Only the captured slave's data and ready are ever looked at.
    always_comb begin
        w_sel_rdata = '0;
        w_sel_ready = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (r_idx == REGION_W'(k)) begin
                w_sel_rdata = d_ReadData[k*DATA_W +: DATA_W];
                w_sel_ready = d_ready[k];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;

    // Held at zero outside ACCESS so every access starts counting from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_ACCESS) begin
            r_wait_cnt <= '0;
        end else if (!w_sel_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // A ready arriving in the expiry cycle takes priority in the FSM.
    assign w_expire = (r_state == S_ACCESS) && !w_sel_ready &&
                      (r_wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_resp_load = 1'b0;
        w_resp_err  = 1'b0;
        w_resp_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_mapped) begin
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_resp_load = 1'b1;
                        w_resp_err  = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (w_sel_ready) begin
                    w_state_nxt = S_RESP;
                    w_resp_load = 1'b1;
                    w_resp_data = r_write ? '0 : w_sel_rdata;
                end else if (w_expire) begin
                    w_state_nxt = S_RESP;
                    w_resp_load = 1'b1;
                    w_resp_err  = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write wins when both request lines are raised together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
        end else if ((r_state == S_IDLE) && w_req) begin
            r_addr  <= m_address;
            r_wdata <= m_WriteData;
            r_write <= m_MemWrite;
            r_idx   <= w_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_resp_load) begin
            r_rdata <= w_resp_data;
            r_err   <= w_resp_err;
        end
    end

    // Strobes decode straight from state so reset drops them without a clock.
    always_comb begin
        w_wr_stb = '0;
        w_rd_stb = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if ((r_state == S_ACCESS) && (r_idx == REGION_W'(k))) begin
                w_wr_stb[k] = r_write;
                w_rd_stb[k] = !r_write;
            end
        end
    end

    assign d_address   = r_addr;
    assign d_WriteData = r_wdata;
    assign d_MemWrite  = w_wr_stb;
    assign d_MemRead   = w_rd_stb;
    assign m_ReadData  = r_rdata;
    assign m_error     = r_err;
    assign m_ready     = (r_state == S_RESP);

endmodule
